// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state, opcodes and register constants
// used by the Controller and the hazard sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned DRN_W = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t R_TYPE = 7'b0110011;
  localparam opcode_t I_TYPE = 7'b0010011;
  localparam opcode_t LOADS  = 7'b0000011;
  localparam opcode_t SAVES  = 7'b0100011;
  localparam opcode_t BR     = 7'b1100011;
  localparam opcode_t JAL    = 7'b1101111;
  localparam opcode_t JALR   = 7'b1100111;
  localparam opcode_t HALT   = 7'b1111111;

  localparam logic [REG_W-1:0] REG_X0 = '0;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == LOADS) || (op == SAVES);
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Control bundle between the pipeline datapath (master) and the hazard
// sequencer (slave).
interface hazard_sequencer_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_halt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic             ex_redirect;
  logic             mem_access;
  logic             dmem_ready;

  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             freeze;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_halt, ex_rd, ex_memread, ex_redirect,
           mem_access, dmem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush, freeze, halted,
           stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_halt, ex_rd, ex_memread, ex_redirect,
           mem_access, dmem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_flush, freeze, halted,
           stall_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush/freeze generation, halt drain sequencing and stall-cycle
// performance counter for the 5-stage core.
module hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_sequencer_if.slave  bus
);

  pipe_state_e      r_state;
  logic [DRN_W-1:0] r_drain_cnt;

  logic w_mem_wait;
  logic w_load_use;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_freeze;
  logic w_halted;
  logic [CNT_W-1:0] w_count;

  assign w_mem_wait = bus.mem_access & ~bus.dmem_ready;

  // A halting instruction never stalls on a load; it drains instead.
  assign w_load_use = bus.ex_memread & (bus.ex_rd != REG_X0) &
                      ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2)) &
                      ~bus.id_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_mem_wait && !bus.ex_redirect && bus.id_halt) begin
            r_state     <= DRAIN;
            r_drain_cnt <= DRN_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          // An older redirect cancels the halt; a memory wait freezes the drain.
          if (!w_mem_wait) begin
            if (bus.ex_redirect) begin
              r_state     <= RUN;
              r_drain_cnt <= '0;
            end else begin
              r_drain_cnt <= r_drain_cnt - DRN_W'(1);
              if (r_drain_cnt == DRN_W'(1)) begin
                r_state <= HALTED;
              end
            end
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state     <= RUN;
          r_drain_cnt <= '0;
        end
      endcase
    end
  end

  // Zero-latency control decode; reset forces every enable low immediately.
  always_comb begin
    w_pc_stall   = 1'b0;
    w_ifid_stall = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_freeze     = 1'b0;
    w_halted     = 1'b0;
    if (!reset) begin
      if (r_state == HALTED) begin
        w_halted     = 1'b1;
        w_pc_stall   = 1'b1;
        w_ifid_stall = 1'b1;
        w_freeze     = 1'b1;
      end else if (w_mem_wait) begin
        w_freeze     = 1'b1;
        w_pc_stall   = 1'b1;
        w_ifid_stall = 1'b1;
      end else if (bus.ex_redirect) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end else if (r_state == DRAIN) begin
        w_pc_stall   = 1'b1;
        w_ifid_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_stall   = 1'b1;
        w_ifid_stall = 1'b1;
        w_idex_flush = 1'b1;
      end else if (bus.id_halt) begin
        w_pc_stall   = 1'b1;
        w_ifid_flush = 1'b1;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (w_pc_stall),
    .o_count (w_count)
  );

  assign bus.pc_stall    = w_pc_stall;
  assign bus.ifid_stall  = w_ifid_stall;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.freeze      = w_freeze;
  assign bus.halted      = w_halted;
  assign bus.stall_count = w_count;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus random
// traffic against a behavioural model of the pipeline-control rules.
module tb_hazard_sequencer;

  localparam int unsigned DRAIN = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] t_rs1, t_rs2, t_rd;
  logic       t_halt, t_memread, t_redirect, t_access, t_ready;

  hazard_sequencer_if #(.CNT_W(16)) u_if ();
  hazard_sequencer_if #(.CNT_W(4))  u_if4 ();

  assign u_if.id_rs1 = t_rs1;      assign u_if4.id_rs1 = t_rs1;
  assign u_if.id_rs2 = t_rs2;      assign u_if4.id_rs2 = t_rs2;
  assign u_if.id_halt = t_halt;    assign u_if4.id_halt = t_halt;
  assign u_if.ex_rd = t_rd;        assign u_if4.ex_rd = t_rd;
  assign u_if.ex_memread = t_memread;   assign u_if4.ex_memread = t_memread;
  assign u_if.ex_redirect = t_redirect; assign u_if4.ex_redirect = t_redirect;
  assign u_if.mem_access = t_access;    assign u_if4.mem_access = t_access;
  assign u_if.dmem_ready = t_ready;     assign u_if4.dmem_ready = t_ready;

  hazard_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) u_dut (
    .clk (clk), .reset (reset), .bus (u_if.slave)
  );

  hazard_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) u_dut4 (
    .clk (clk), .reset (reset), .bus (u_if4.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: halted flag, remaining drain cycles, ideal stall counts.
  bit         m_halted;
  int         m_drain;
  int         m_cnt;
  int         m_cnt4;
  logic [5:0] e_vec;

  function automatic void model_reset();
    m_halted = 1'b0;
    m_drain  = 0;
    m_cnt    = 0;
    m_cnt4   = 0;
  endfunction

  // {pc_stall, ifid_stall, ifid_flush, idex_flush, freeze, halted}
  function automatic logic [5:0] model_outs();
    logic lu;
    lu = t_memread && (t_rd != 5'd0) && ((t_rd == t_rs1) || (t_rd == t_rs2)) && !t_halt;
    if (reset)                 return 6'b000000;
    if (m_halted)              return 6'b110011;
    if (t_access && !t_ready)  return 6'b110010;
    if (t_redirect)            return 6'b001100;
    if (m_drain > 0)           return 6'b101000;
    if (lu)                    return 6'b110100;
    if (t_halt)                return 6'b101000;
    return 6'b000000;
  endfunction

  function automatic logic [25:0] got_vec();
    return {u_if.pc_stall, u_if.ifid_stall, u_if.ifid_flush, u_if.idex_flush,
            u_if.freeze, u_if.halted, u_if.stall_count, u_if4.stall_count};
  endfunction

  function automatic logic [25:0] exp_vec();
    return {e_vec, 16'(m_cnt), 4'(m_cnt4)};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic halt, input logic memread, input logic redirect,
                       input logic access, input logic ready);
    t_rs1 = rs1; t_rs2 = rs2; t_rd = rd; t_halt = halt;
    t_memread = memread; t_redirect = redirect; t_access = access; t_ready = ready;
    #3;
    e_vec = model_outs();
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    logic mw;
    mw = t_access && !t_ready;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (e_vec[5]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (!m_halted && !mw) begin
        if (t_redirect) m_drain = 0;
        else if (m_drain > 0) begin
          m_drain--;
          if (m_drain == 0) m_halted = 1'b1;
        end else if (t_halt) m_drain = DRAIN;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    drive(5'd3, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL load_use got=%h exp=%h", got_vec(), exp_vec());
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (got_vec() !== exp_vec() || u_if.stall_count !== 16'd1) begin
      miscompares++;
      $display("FAIL load_use_x0 got=%h exp=%h cnt_req=1", got_vec(), exp_vec());
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL load_use_x0_b got=%h exp=%h", got_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_redirect_vs_load_use();
    drive(5'd7, 5'd2, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL redirect_vs_lu got=%h exp=%h", got_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_random_run();
    logic [4:0] rs1, rs2, rd;
    logic halt, rdir, acc, rdy, mr;
    for (int i = 0; i < 300; i++) begin
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      mr   = 1'($urandom_range(0, 1));
      rdir = ($urandom_range(0, 3) == 0);
      acc  = ($urandom_range(0, 2) == 0);
      rdy  = 1'($urandom_range(0, 1));
      halt = ($urandom_range(0, 7) == 0);
      if (halt && !(acc && !rdy)) rdir = 1'b1;
      drive(rs1, rs2, rd, halt, mr, rdir, acc, rdy);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_halt_drain();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (i == 0) drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (i < 4) idle();
      else drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++;
      if (got_vec() !== exp_vec() || u_if.halted !== (i >= 4)) begin
        miscompares++;
        $display("FAIL halt_drain cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      tick();
    end
    vectors++;
    if (u_if.stall_count !== 16'd24 || u_if4.stall_count !== 4'd15) begin
      miscompares++;
      $display("FAIL saturation cnt=%0d cnt4=%0d req=24/15", u_if.stall_count, u_if4.stall_count);
    end
  endtask

  task automatic test_drain_abort();
    bit seen_halt = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (i == 2) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      else idle();
      if (u_if.halted === 1'b1) seen_halt = 1'b1;
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL drain_abort cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      tick();
    end
    vectors++;
    if (seen_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_abort_halted got=1 req=0");
    end
  endtask

  task automatic test_mem_wait_drain();
    int first_halt = -1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 0) drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (i >= 2 && i <= 5) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else idle();
      if (u_if.halted === 1'b1 && first_halt < 0) first_halt = i;
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL mem_wait cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      tick();
    end
    vectors++;
    if (first_halt != 8) begin
      miscompares++;
      $display("FAIL mem_wait_delay first_halt=%0d req=8", first_halt);
    end
  endtask

  task automatic test_reset_async();
    do_reset();
    for (int phase = 0; phase < 2; phase++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < (phase == 0 ? 1 : 5); i++) begin
        idle();
        tick();
      end
      idle();
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      e_vec = model_outs();
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_async phase=%0d got=%h exp=%h", phase, got_vec(), exp_vec());
      end
      tick();
      reset = 1'b0;
    end
    test_load_use();
  endtask

  initial begin
    reset = 1'b1;
    t_rs1 = '0; t_rs2 = '0; t_rd = '0; t_halt = 1'b0;
    t_memread = 1'b0; t_redirect = 1'b0; t_access = 1'b0; t_ready = 1'b1;
    model_reset();
    e_vec = '0;
    #1;
    test_reset();
    test_load_use();
    test_redirect_vs_load_use();
    test_random_run();
    test_halt_drain();
    test_drain_abort();
    test_mem_wait_drain();
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
